// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for pipelined_cla_adder
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor
// One GROUP-bit lookahead group per stage; operands and partial sums skew along the pipe.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int STAGES = WIDTH / GROUP;

  logic [STAGES-1:0]            vld_d, vld_q;
  logic [STAGES-1:0]            carry_d, carry_q;
  logic [STAGES-1:0]            msb_c_d, msb_c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_d, a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_d, b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_d, sum_q;
  logic                         en;
  logic                         unused_ok;

  // Flattened sum-of-products lookahead: every carry is built directly from p/g and c0.
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] p,
                                               input logic [GROUP-1:0] g,
                                               input logic             c0);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // A single enable freezes the whole pipe, so bubbles are held rather than collapsed.
  assign en = bus.out_ready | ~vld_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_s, b_s, sum_s, sum_n;
    logic             c_s, v_s;
    logic [GROUP:0]   cy;

    if (k == 0) begin : g_first
      assign a_s   = bus.a;
      assign b_s   = bus.sub ? ~bus.b : bus.b;
      assign c_s   = bus.sub | bus.cin;
      assign sum_s = '0;
      assign v_s   = bus.in_valid;
    end else begin : g_next
      assign a_s   = a_q[k-1];
      assign b_s   = b_q[k-1];
      assign c_s   = carry_q[k-1];
      assign sum_s = sum_q[k-1];
      assign v_s   = vld_q[k-1];
    end

    always_comb begin
      cy    = lookahead(a_s[k*GROUP +: GROUP] ^ b_s[k*GROUP +: GROUP],
                        a_s[k*GROUP +: GROUP] & b_s[k*GROUP +: GROUP], c_s);
      sum_n = sum_s;
      sum_n[k*GROUP +: GROUP] = a_s[k*GROUP +: GROUP] ^ b_s[k*GROUP +: GROUP] ^ cy[GROUP-1:0];
    end

    assign a_d[k]     = a_s;
    assign b_d[k]     = b_s;
    assign sum_d[k]   = sum_n;
    assign carry_d[k] = cy[GROUP];
    assign msb_c_d[k] = cy[GROUP-1];
    assign vld_d[k]   = v_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      msb_c_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else if (en) begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      msb_c_q <= msb_c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = msb_c_q[STAGES-1] ^ carry_q[STAGES-1];

  // Consumed operand bits and early-stage MSB carries are dead by construction.
  assign unused_ok = ^{a_q, b_q, msb_c_q};
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(16)) if16 ();
  pipelined_cla_adder_if #(.WIDTH(8))  if8 ();
  pipelined_cla_adder_if #(.WIDTH(32)) if32 ();

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  pipelined_cla_adder #(.WIDTH(8),  .GROUP(8)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  logic [15:0] st_a [8] = '{16'h0001, 16'h1234, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h4000, 16'hABCD, 16'h8000};
  logic [15:0] st_b [8] = '{16'h0002, 16'h1111, 16'h0001, 16'h0001, 16'hFFFF, 16'h4000, 16'h5433, 16'h8000};
  logic [15:0] st_s [8] = '{16'h0003, 16'h2345, 16'h0100, 16'h1000, 16'hFFFE, 16'h8000, 16'h0000, 16'h0000};
  logic        st_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        st_o [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, be, full, lo;
    logic        c0, co, ci;
    mask = (64'd1 << w) - 64'd1;
    be   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    c0   = sub | cin;
    full = {32'd0, a} + be + {63'd0, c0};
    co   = full[w];
    lo   = ({32'd0, a} & (mask >> 1)) + (be & (mask >> 1)) + {63'd0, c0};
    ci   = lo[w-1];
    return {ci ^ co, co, full[31:0] & mask[31:0]};
  endfunction

  task automatic run_one16(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    bit seen;
    @(posedge clk); #1;
    if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
    if16.in_valid = 1'b1; if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if16.a = ~a; if16.b = ~b; if16.cin = ~cin; if16.sub = ~sub;
    lat = 1; seen = 1'b0;
    repeat (20) begin
      if (!seen) begin
        @(negedge clk);
        if (if16.out_valid) seen = 1'b1;
        else begin @(posedge clk); lat++; end
      end
    end
    check({tag, "_lat"}, seen ? lat : 0, 4);
    check({tag, "_sum"}, if16.sum, e_sum);
    check({tag, "_cout"}, if16.cout, e_cout);
    check({tag, "_ovf"}, if16.ovf, e_ovf);
    @(posedge clk); #1;
  endtask

  task automatic stream16(input bit stall);
    int acc = 0, pops = 0, cyc = 0, first_pop = -1, last_pop = -1;
    logic [15:0] held = '0;
    bit was_stall = 1'b0;
    while (pops < 8 && cyc < 60) begin
      @(posedge clk); #1;
      if16.out_ready = !(stall && cyc >= 5 && cyc < 8);
      if (acc < 8) begin
        if16.in_valid = 1'b1; if16.a = st_a[acc]; if16.b = st_b[acc];
        if16.cin = 1'b0; if16.sub = 1'b0;
      end else if16.in_valid = 1'b0;
      @(negedge clk);
      if (if16.out_valid && !if16.out_ready) begin
        check("stall_in_ready", if16.in_ready, 0);
        if (was_stall) check("stall_hold", if16.sum, held);
        held = if16.sum; was_stall = 1'b1;
      end else was_stall = 1'b0;
      if (if16.in_valid && if16.in_ready) acc++;
      if (if16.out_valid && if16.out_ready) begin
        check("stream_res", {if16.ovf, if16.cout, if16.sum}, {st_o[pops], st_c[pops], st_s[pops]});
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      cyc++;
    end
    check(stall ? "bp_count" : "stream_count", pops, 8);
    if (!stall) check("stream_consecutive", last_pop - first_pop, 7);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stream_drain", if16.out_valid, 0);
  endtask

  task automatic sweep8();
    logic [33:0] expq[$];
    int acc = 0, pops = 0, cyc = 0, lat = 1;
    bit pending = 1'b0, seen = 1'b0;
    @(posedge clk); #1;
    if8.out_ready = 1'b1; if8.in_valid = 1'b1;
    if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0; if8.sub = 1'b0;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (20) begin
      if (!seen) begin
        @(negedge clk);
        if (if8.out_valid) seen = 1'b1;
        else begin @(posedge clk); lat++; end
      end
    end
    check("sw8_lat", seen ? lat : 0, 1);
    check("sw8_probe", {if8.ovf, if8.cout, if8.sum}, 10'h280);
    while ((acc < 10000 || pops < 10000) && cyc < 30000) begin
      @(posedge clk); #1;
      if (!pending) begin
        if (acc < 10000 && $urandom_range(3) != 0) begin
          if8.a = 8'($urandom); if8.b = 8'($urandom);
          if8.cin = 1'($urandom); if8.sub = 1'($urandom);
          if8.in_valid = 1'b1; pending = 1'b1;
        end else if8.in_valid = 1'b0;
      end
      if8.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (if8.in_valid && if8.in_ready) begin
        expq.push_back(model(8, {24'd0, if8.a}, {24'd0, if8.b}, if8.cin, if8.sub));
        acc++; pending = 1'b0;
      end
      if (if8.out_valid && if8.out_ready) begin
        if (expq.size() == 0) check("sw8_extra", 1, 0);
        else check("sw8_res", {if8.ovf, if8.cout, 24'd0, if8.sum}, expq.pop_front());
        pops++;
      end
      cyc++;
    end
    check("sw8_count", pops, 10000);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic sweep32();
    logic [33:0] expq[$];
    int acc = 0, pops = 0, cyc = 0, lat = 1;
    bit pending = 1'b0, seen = 1'b0;
    @(posedge clk); #1;
    if32.out_ready = 1'b1; if32.in_valid = 1'b1;
    if32.a = 32'hFFFF_FFFF; if32.b = 32'h0000_0001; if32.cin = 1'b0; if32.sub = 1'b0;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    repeat (20) begin
      if (!seen) begin
        @(negedge clk);
        if (if32.out_valid) seen = 1'b1;
        else begin @(posedge clk); lat++; end
      end
    end
    check("sw32_lat", seen ? lat : 0, 8);
    check("sw32_probe", {if32.ovf, if32.cout, if32.sum}, 34'h1_0000_0000);
    while ((acc < 10000 || pops < 10000) && cyc < 30000) begin
      @(posedge clk); #1;
      if (!pending) begin
        if (acc < 10000 && $urandom_range(3) != 0) begin
          if32.a = $urandom; if32.b = $urandom;
          if32.cin = 1'($urandom); if32.sub = 1'($urandom);
          if32.in_valid = 1'b1; pending = 1'b1;
        end else if32.in_valid = 1'b0;
      end
      if32.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (if32.in_valid && if32.in_ready) begin
        expq.push_back(model(32, if32.a, if32.b, if32.cin, if32.sub));
        acc++; pending = 1'b0;
      end
      if (if32.out_valid && if32.out_ready) begin
        if (expq.size() == 0) check("sw32_extra", 1, 0);
        else check("sw32_res", {if32.ovf, if32.cout, if32.sum}, expq.pop_front());
        pops++;
      end
      cyc++;
    end
    check("sw32_count", pops, 10000);
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
  endtask

  initial begin
    bit stale;
    rst = 1'b1;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0; if16.out_ready = 1'b1;
    if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0; if8.sub  = 1'b0; if8.out_ready  = 1'b1;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0; if32.sub = 1'b0; if32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", if16.out_valid, 0);
    check("rst_sum", if16.sum, 0);
    check("rst_cout", if16.cout, 0);
    check("rst_ovf", if16.ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", if16.in_ready, 1);

    run_one16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one16("add_cin",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_one16("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one16("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one16("sub_cin",   16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    stream16(1'b0);
    stream16(1'b1);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if16.out_ready = 1'b1; if16.in_valid = 1'b1;
      if16.a = 16'(i + 1); if16.b = 16'h0001; if16.cin = 1'b0; if16.sub = 1'b0;
    end
    @(posedge clk); #1;
    if16.in_valid = 1'b0; if16.out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", if16.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid", if16.out_valid, 0);
    check("rst_async_sum", if16.sum, 0);
    @(posedge clk); #1;
    rst = 1'b0; if16.out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if16.out_valid) stale = 1'b1;
    end
    check("rst_no_stale", stale, 0);
    run_one16("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    sweep8();
    sweep32();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
